vec_sequencer: RTL and testbench
================================

VEC_SEQUENCER -- requirements
Module: vec_sequencer

Interface
REQ-001 The module SHALL have parameter MUL_SEL_CFG, default 2'b00, giving the value driven on mul_sel during the MUL state.
REQ-002 The module SHALL have parameter ADD_SEL_CFG, default 2'b00, giving the value driven on add_sel during the ADD state.
REQ-003 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; every flop samples on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, active-high and synchronous.
REQ-005 The port start SHALL be an input, 1 bit wide, carrying the job request, sampled only in IDLE.
REQ-006 The port n SHALL be an input, 32 bits wide, carrying the element count, captured when start is accepted.
REQ-007 The port abort SHALL be an input, 1 bit wide, that cancels the running job.
REQ-008 The port mem_ready SHALL be an input, 1 bit wide, indicating that the memory side completes this cycle's load or store.
REQ-009 The ports load_a_en, load_b_en, load_c_en, mul_en, add_en and store_c_en SHALL each be an output, 1 bit wide, acting as a datapath strobe.
REQ-010 The ports mul_sel and add_sel SHALL each be an output, 2 bits wide, acting as a datapath operand select.
REQ-011 The port idx SHALL be an output, 32 bits wide, carrying the current element index.
REQ-012 The port busy SHALL be an output, 1 bit wide, high whenever the state is not IDLE.
REQ-013 The port done SHALL be an output, 1 bit wide, pulsed for one cycle when a job completes.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, LD_AB, LD_C, MUL, ADD, ST_C, FIN. All outputs SHALL be Moore outputs decoded from the state.
REQ-015 In IDLE, start=1 SHALL load n into an internal n_reg and clear idx to 0. The next state SHALL be FIN if n==0, otherwise LD_AB.
REQ-016 LD_AB SHALL assert load_a_en and load_b_en. It SHALL stay in LD_AB while mem_ready=0 and go to LD_C when mem_ready=1.
REQ-017 LD_C SHALL assert load_c_en. It SHALL stay in LD_C while mem_ready=0 and go to MUL when mem_ready=1.
REQ-018 MUL SHALL assert mul_en with mul_sel=MUL_SEL_CFG for exactly one cycle, then go to ADD.
REQ-019 ADD SHALL assert add_en with add_sel=ADD_SEL_CFG for exactly one cycle, then go to ST_C.
REQ-020 ST_C SHALL assert store_c_en and hold while mem_ready=0. With mem_ready=1:
- if idx==n_reg-1, go to FIN with idx unchanged;
- otherwise increment idx and go to LD_AB.
REQ-021 FIN SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-022 mul_sel and add_sel SHALL be 2'b00 outside MUL and ADD respectively. All strobes SHALL be 0 in IDLE and FIN.
REQ-023 At most one of the groups {load_a_en/load_b_en}, load_c_en, mul_en, add_en, store_c_en SHALL be high in any cycle.
REQ-024 With mem_ready held at 1, each element SHALL take exactly 5 cycles. A job accepted at cycle t SHALL assert done at cycle t+1+5*n.
REQ-025 start while busy=1 SHALL be ignored, and n changes after acceptance SHALL have no effect.
REQ-026 abort=1 in any state other than IDLE or FIN SHALL force IDLE on the next edge with no done pulse and idx cleared. abort SHALL take priority over mem_ready and start.
REQ-027 idx arithmetic SHALL be 32-bit unsigned. n=32'hFFFFFFFF SHALL terminate at idx=32'hFFFFFFFE without wrap.

Reset
REQ-028 When rst=1 at a rising edge, the module SHALL enter IDLE, clear idx and n_reg, and drive all strobes, busy and done to 0 and both sel outputs to 2'b00. rst SHALL take priority over abort and start in every state, including mid-job.

Verification
REQ-029 The bench SHALL cover: n=1, mem_ready=1, start at cycle 0 -> LD_AB@1, LD_C@2, MUL@3, ADD@4, ST_C@5, done@6, busy low@7, idx=0 throughout.
REQ-030 The bench SHALL cover: n=3, mem_ready=1 -> idx reads 0,1,2 across 15 cycles, done at cycle 16, and no strobe overlap in any cycle.
REQ-031 The bench SHALL cover: n=2, mem_ready=0 for 3 cycles in LD_C of element 0 -> load_c_en held for 4 cycles and done delayed by 3 (cycle 14).
REQ-032 The bench SHALL cover: n=0 -> FIN on the next cycle, done at cycle 1, and zero strobes asserted.
REQ-033 The bench SHALL cover: n=4, abort asserted in MUL of element 1 -> IDLE next cycle, done never pulses, idx=0, and a new start with n=1 runs normally.
REQ-034 The bench SHALL cover: rst asserted in ST_C with mem_ready=1 -> IDLE, all outputs 0 and no done; a second start while busy (n=9) is ignored and the original count completes.

Source files
------------

// File: rtl/vec_sequencer.sv
// vec_sequencer: control FSM that walks a vector job element by element.
// For each element it loads A/B, loads C, multiplies, adds and stores C,
// waiting on mem_ready for the three memory phases. All datapath strobes
// and status outputs are Moore outputs decoded from the current state.
module vec_sequencer #(
    parameter logic [1:0] MUL_SEL_CFG = 2'b00,
    parameter logic [1:0] ADD_SEL_CFG = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] n,
    input  logic        abort,
    input  logic        mem_ready,
    output logic        load_a_en,
    output logic        load_b_en,
    output logic        load_c_en,
    output logic        mul_en,
    output logic        add_en,
    output logic        store_c_en,
    output logic [1:0]  mul_sel,
    output logic [1:0]  add_sel,
    output logic [31:0] idx,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LD_AB = 3'd1;
    localparam logic [2:0] S_LD_C  = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_ADD   = 3'd4;
    localparam logic [2:0] S_ST_C  = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]  r_state;
    logic [31:0] r_idx;
    logic [31:0] r_n_reg;

    logic [2:0]  w_state_nxt;
    logic [31:0] w_idx_nxt;
    logic [31:0] w_n_reg_nxt;
    logic        w_last;
    logic        w_abortable;

    // The final element is the one whose index equals n_reg-1; n_reg is
    // never zero while in ST_C because n==0 jumps straight to FIN.
    assign w_last      = (r_idx == (r_n_reg - 32'd1));
    assign w_abortable = (r_state != S_IDLE) && (r_state != S_FIN);

    // Next-state, index and count update; abort overrides every other input.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_n_reg_nxt = r_n_reg;
        if (abort && w_abortable) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_n_reg_nxt = n;
                        w_idx_nxt   = 32'd0;
                        w_state_nxt = (n == 32'd0) ? S_FIN : S_LD_AB;
                    end
                end
                S_LD_AB: begin
                    if (mem_ready) begin
                        w_state_nxt = S_LD_C;
                    end
                end
                S_LD_C: begin
                    if (mem_ready) begin
                        w_state_nxt = S_MUL;
                    end
                end
                S_MUL: begin
                    w_state_nxt = S_ADD;
                end
                S_ADD: begin
                    w_state_nxt = S_ST_C;
                end
                S_ST_C: begin
                    if (mem_ready) begin
                        if (w_last) begin
                            w_state_nxt = S_FIN;
                        end else begin
                            w_idx_nxt   = r_idx + 32'd1;
                            w_state_nxt = S_LD_AB;
                        end
                    end
                end
                S_FIN: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = 32'd0;
                end
            endcase
        end
    end

    // State registers; reset wins over abort and start in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 32'd0;
            r_n_reg <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_n_reg <= w_n_reg_nxt;
        end
    end

    // Moore output decode: exactly one strobe group per active state.
    always_comb begin
        load_a_en  = 1'b0;
        load_b_en  = 1'b0;
        load_c_en  = 1'b0;
        mul_en     = 1'b0;
        add_en     = 1'b0;
        store_c_en = 1'b0;
        mul_sel    = 2'b00;
        add_sel    = 2'b00;
        done       = 1'b0;
        case (r_state)
            S_LD_AB: begin
                load_a_en = 1'b1;
                load_b_en = 1'b1;
            end
            S_LD_C: begin
                load_c_en = 1'b1;
            end
            S_MUL: begin
                mul_en  = 1'b1;
                mul_sel = MUL_SEL_CFG;
            end
            S_ADD: begin
                add_en  = 1'b1;
                add_sel = ADD_SEL_CFG;
            end
            S_ST_C: begin
                store_c_en = 1'b1;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign idx  = r_idx;

endmodule

// File: tb/tb_vec_sequencer.sv
// Bench for vec_sequencer: a job-level reference model expands each job
// (element count, memory stall plan, optional abort/reset) into the cycle
// sequence of operations it must produce; a monitor compares every cycle.
module tb_vec_sequencer;

    localparam logic [1:0] MSEL = 2'b10;
    localparam logic [1:0] ASEL = 2'b01;

    localparam int OP_IDLE = 0;
    localparam int OP_LDAB = 1;
    localparam int OP_LDC  = 2;
    localparam int OP_MUL  = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_ST   = 5;
    localparam int OP_FIN  = 6;

    typedef struct packed {
        logic        ld_a;
        logic        ld_b;
        logic        ld_c;
        logic        mul;
        logic        add;
        logic        st;
        logic [1:0]  msel;
        logic [1:0]  asel;
        logic        bsy;
        logic        dn;
        logic [31:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] n = 32'd0;
    logic        abort = 1'b0;
    logic        mem_ready = 1'b0;
    logic        load_a_en, load_b_en, load_c_en, mul_en, add_en, store_c_en;
    logic [1:0]  mul_sel, add_sel;
    logic [31:0] idx;
    logic        busy, done;

    exp_t        sb[$];
    int          opq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] cur_idx = 32'd0;

    vec_sequencer #(.MUL_SEL_CFG(MSEL), .ADD_SEL_CFG(ASEL)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .abort(abort),
        .mem_ready(mem_ready),
        .load_a_en(load_a_en), .load_b_en(load_b_en), .load_c_en(load_c_en),
        .mul_en(mul_en), .add_en(add_en), .store_c_en(store_c_en),
        .mul_sel(mul_sel), .add_sel(add_sel), .idx(idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // What the outputs must look like while the sequencer performs op on element i.
    function automatic exp_t expect_of(input int op, input logic [31:0] i);
        exp_t e;
        e     = '0;
        e.idx = i;
        e.bsy = (op != OP_IDLE);
        case (op)
            OP_LDAB: begin e.ld_a = 1'b1; e.ld_b = 1'b1; end
            OP_LDC:  e.ld_c = 1'b1;
            OP_MUL:  begin e.mul = 1'b1; e.msel = MSEL; end
            OP_ADD:  begin e.add = 1'b1; e.asel = ASEL; end
            OP_ST:   e.st = 1'b1;
            OP_FIN:  e.dn = 1'b1;
            default: e.dn = 1'b0;
        endcase
        return e;
    endfunction

    // Drive one cycle's inputs, record what the DUT must show this cycle.
    task automatic step(input int op, input logic [31:0] i, input logic mr,
                        input logic st, input logic [31:0] nv,
                        input logic ab, input logic rs);
        mem_ready = mr;
        start     = st;
        n         = nv;
        abort     = ab;
        rst       = rs;
        sb.push_back(expect_of(op, i));
        opq.push_back(op);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int cnt);
        for (int c = 0; c < cnt; c++)
            step(OP_IDLE, cur_idx, 1'($urandom), 1'b0, $urandom, 1'b0, 1'b0);
    endtask

    // One job: n elements, each LD_AB/LD_C/ST_C phase lasting 1+stall cycles.
    // kill_elem/kill_op select the cycle where abort (or rst) is raised.
    task automatic run_job(input int unsigned nv, input int max_stall,
                           input int st_elem, input int st_op, input int st_cnt,
                           input int kill_elem, input int kill_op,
                           input bit kill_rst, input bit poke);
        int   s;
        bit   memop;
        bit   kill;
        logic mr;
        logic pst;
        logic [31:0] pn;
        step(OP_IDLE, cur_idx, 1'($urandom), 1'b1, nv, 1'b0, 1'b0);
        cur_idx = 32'd0;
        for (int k = 0; k < int'(nv); k++) begin
            for (int op = OP_LDAB; op <= OP_ST; op++) begin
                memop = (op == OP_LDAB) || (op == OP_LDC) || (op == OP_ST);
                if (!memop) s = 0;
                else if (k == st_elem && op == st_op) s = st_cnt;
                else s = $urandom_range(0, max_stall);
                for (int j = 0; j <= s; j++) begin
                    kill = (k == kill_elem) && (op == kill_op) && (j == s);
                    mr   = memop ? logic'(j == s) : 1'($urandom);
                    pst  = poke ? 1'($urandom) : 1'b0;
                    pn   = poke ? 32'd9 : $urandom;
                    step(op, 32'(k), mr, pst, pn, kill && !kill_rst, kill && kill_rst);
                    if (kill) begin
                        cur_idx = 32'd0;
                        return;
                    end
                end
            end
        end
        cur_idx = (nv == 0) ? 32'd0 : 32'(nv - 1);
        pst = poke ? 1'($urandom) : 1'b0;
        pn  = poke ? 32'd9 : $urandom;
        step(OP_FIN, cur_idx, 1'($urandom), pst, pn, 1'b0, 1'b0);
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        int   op;
        int   grp;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            op = opq.pop_front();
            a  = {load_a_en, load_b_en, load_c_en, mul_en, add_en, store_c_en,
                  mul_sel, add_sel, busy, done, idx};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs cyc=%0d op=%0d actual=%h required=%h", cyc, op, a, e);
            end
            grp = int'(load_a_en | load_b_en) + int'(load_c_en) + int'(mul_en)
                + int'(add_en) + int'(store_c_en);
            total++;
            if (grp > 1) begin
                bad++;
                $display("FAIL strobe_overlap cyc=%0d actual=%0d required<=1", cyc, grp);
            end
        end
        cyc++;
    end

    initial begin
        int unsigned rn;
        @(posedge clk);
        #1;
        // reset state, held for two cycles with start asserted
        step(OP_IDLE, 32'd0, 1'b1, 1'b1, 32'd5, 1'b0, 1'b1);
        step(OP_IDLE, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        // single element, no stalls
        run_job(1, 0, -1, 0, 0, -1, 0, 1'b0, 1'b0);
        idle_cycles(2);
        // three elements, no stalls
        run_job(3, 0, -1, 0, 0, -1, 0, 1'b0, 1'b0);
        idle_cycles(2);
        // two elements, LD_C of element 0 stalls three cycles
        run_job(2, 0, 0, OP_LDC, 3, -1, 0, 1'b0, 1'b0);
        idle_cycles(2);
        // empty job
        run_job(0, 0, -1, 0, 0, -1, 0, 1'b0, 1'b0);
        idle_cycles(2);
        // abort in MUL of element 1, then a normal single-element job
        run_job(4, 0, -1, 0, 0, 1, OP_MUL, 1'b0, 1'b0);
        idle_cycles(2);
        run_job(1, 0, -1, 0, 0, -1, 0, 1'b0, 1'b0);
        idle_cycles(2);
        // abort while a load is completing
        run_job(3, 2, -1, 0, 0, 2, OP_LDAB, 1'b0, 1'b1);
        idle_cycles(1);
        // reset in ST_C with mem_ready high
        run_job(3, 1, -1, 0, 0, 1, OP_ST, 1'b1, 1'b0);
        idle_cycles(2);
        // start n=9 while busy is ignored
        run_job(5, 1, -1, 0, 0, -1, 0, 1'b0, 1'b1);
        idle_cycles(2);
        // random jobs with random stalls and busy-time noise
        for (int r = 0; r < 8; r++) begin
            rn = $urandom_range(0, 6);
            run_job(rn, 3, -1, 0, 0, -1, 0, 1'b0, 1'($urandom));
            idle_cycles($urandom_range(0, 2));
        end
        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
